// File: rtl/instr_loader.sv
// Boot loader: framed byte stream (SYNC, count, big-endian words, XOR checksum) into instruction ROM.
// Optional inactivity timeout enabled by defining LOADER_TIMEOUT_EN.
module instr_loader #(
  parameter int          N       = 5,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          TIMEOUT = 1024
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         wr_en,
  output logic [N-1:0] wr_addr,
  output logic [31:0]  wr_data,
  output logic         cpu_reset,
  output logic         done,
  output logic         error,
  output logic [N:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} state_t;

  state_t       state, state_next;
  logic         accept;
  logic         count_ok;
  logic         last_word;
  logic         timed_out;
  logic [N:0]   frame_len;
  logic [1:0]   byte_idx;
  logic [23:0]  word_buf;
  logic [7:0]   checksum;

  assign in_ready  = (state != DONE);
  assign accept    = in_valid && in_ready;
  assign count_ok  = (in_data != 8'd0) && (int'(in_data) <= (1 << N));
  assign last_word = ((words_loaded + (N+1)'(1)) == frame_len);

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  // Counts cycles since the last accepted byte or state change; saturates at the limit.
  always_ff @(posedge Clk) begin
    if (Reset || accept || (state_next != state)) idle_cnt <= '0;
    else if (!timed_out)                          idle_cnt <= idle_cnt + TW'(1);
  end

  assign timed_out = (idle_cnt == TW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && in_data == SYNC) state_next = COUNT;
      COUNT:   if (accept) state_next = count_ok ? DATA : ERROR;
      DATA:    if (accept && byte_idx == 2'd3 && last_word) state_next = CHECK;
      CHECK:   if (accept) state_next = (in_data == checksum) ? DONE : ERROR;
      DONE:    state_next = DONE;
      ERROR:   if (accept && in_data == SYNC) state_next = COUNT;
      default: state_next = IDLE;
    endcase
    if (timed_out && !accept && (state inside {COUNT, DATA, CHECK}))
      state_next = ERROR;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      frame_len    <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      checksum     <= '0;
    end else begin
      wr_en     <= 1'b0;
      done      <= (state_next == DONE);
      error     <= (state_next == ERROR);
      cpu_reset <= (state_next != DONE);
      if (accept) begin
        case (state)
          COUNT: if (count_ok) begin
            frame_len    <= (N+1)'(in_data);
            words_loaded <= '0;
            checksum     <= '0;
            byte_idx     <= '0;
          end
          DATA: begin
            checksum <= checksum ^ in_data;
            word_buf <= {word_buf[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en        <= 1'b1;
              wr_addr      <= words_loaded[N-1:0];
              wr_data      <= {word_buf, in_data};
              words_loaded <= words_loaded + (N+1)'(1);
            end
          end
          default: ;
        endcase
      end
      // A byte index left mid-word by a timeout must not leak into the next frame.
      if (state_next == ERROR) byte_idx <= '0;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (N=5, TIMEOUT=16).
module tb_instr_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, cpu_reset, done, error;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  words_loaded;

  int errors = 0;
  int checks = 0;

  logic [7:0]  frame [11] = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'h8C, 8'h09, 8'h00, 8'h00, 8'hA8};
  logic [4:0]  wa_q [$];
  logic [31:0] wd_q [$];

  instr_loader #(.N(5), .SYNC(8'hA5), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (wr_en) begin
    wa_q.push_back(wr_addr);
    wd_q.push_back(wr_data);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    in_data  = b;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(frame[i]);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    in_valid = 1'b0;
    Reset    = 1'b1;
    @(negedge Clk);
    Reset    = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_writes(input string tag, input int n);
    checks++; if (wa_q.size() !== n) begin errors++; $display("FAIL %s_wcount: got %0d want %0d", tag, wa_q.size(), n); end
    if (n == 2 && wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 5'd0 || wd_q[0] !== 32'h20080005) begin errors++; $display("FAIL %s_w0: got %h@%0d want 20080005@0", tag, wd_q[0], wa_q[0]); end
      checks++; if (wa_q[1] !== 5'd1 || wd_q[1] !== 32'h8C090000) begin errors++; $display("FAIL %s_w1: got %h@%0d want 8c090000@1", tag, wd_q[1], wa_q[1]); end
    end
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err, input logic e_rst);
    checks++; if (done !== e_done) begin errors++; $display("FAIL %s_done: got %b want %b", tag, done, e_done); end
    checks++; if (error !== e_err) begin errors++; $display("FAIL %s_error: got %b want %b", tag, error, e_err); end
    checks++; if (cpu_reset !== e_rst) begin errors++; $display("FAIL %s_cpu_reset: got %b want %b", tag, cpu_reset, e_rst); end
  endtask

  task automatic test_reset();
    do_reset();
    check_status("reset", 1'b0, 1'b0, 1'b1);
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr: got en=%b addr=%0d data=%h want 0", wr_en, wr_addr, wr_data); end
    checks++; if (words_loaded !== 6'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_good_frame();
    do_reset();
    send_range(0, 9);
    @(negedge Clk);
    checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL good_pre_ck: got cpu_reset=%b done=%b want 1/0", cpu_reset, done); end
    in_data = 8'hA8;
    in_valid = 1'b1;
    idle(1);
    check_status("good", 1'b1, 1'b0, 1'b0);
    check_writes("good", 2);
    checks++; if (words_loaded !== 6'd2) begin errors++; $display("FAIL good_words: got %0d want 2", words_loaded); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL good_ready: got %b want 0", in_ready); end
    // DONE is sticky: a further frame is ignored.
    send_range(0, 10);
    idle(2);
    check_status("sticky", 1'b1, 1'b0, 1'b0);
    check_writes("sticky", 2);
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send_range(0, 9);
    send_byte(8'hA9);
    idle(1);
    check_status("badck", 1'b0, 1'b1, 1'b1);
    check_writes("badck", 2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL badck_ready: got %b want 1", in_ready); end
    wa_q.delete();
    wd_q.delete();
    send_range(0, 10);
    idle(1);
    check_status("retry", 1'b1, 1'b0, 1'b0);
    check_writes("retry", 2);
  endtask

  task automatic test_junk_and_gaps();
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    send_range(0, 1);
    for (int i = 2; i <= 9; i++) begin
      send_byte(frame[i]);
      idle(1);
    end
    send_byte(frame[10]);
    idle(1);
    check_status("gaps", 1'b1, 1'b0, 1'b0);
    check_writes("gaps", 2);
  endtask

  task automatic test_bad_count();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(1);
    check_status("cnt0", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h21);
    idle(3);
    check_status("cnt33", 1'b0, 1'b1, 1'b1);
    check_writes("cnt_bad", 0);
    // 0x20 is the largest legal count and must not error.
    send_byte(8'hA5);
    send_byte(8'h20);
    idle(1);
    check_status("cnt32", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_range(0, 7);
    idle(2);
    check_writes("mid_pre", 1);
    if (wa_q.size() == 1) begin
      checks++; if (wa_q[0] !== 5'd0 || wd_q[0] !== 32'h20080005) begin errors++; $display("FAIL mid_w0: got %h@%0d want 20080005@0", wd_q[0], wa_q[0]); end
    end
    do_reset();
    check_status("mid_rst", 1'b0, 1'b0, 1'b1);
    checks++; if (words_loaded !== 6'd0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL mid_rst_regs: got words=%0d addr=%0d data=%h want 0", words_loaded, wr_addr, wr_data); end
    send_range(0, 10);
    idle(1);
    check_status("mid_good", 1'b1, 1'b0, 1'b0);
    check_writes("mid_good", 2);
  endtask

  task automatic test_stall();
    do_reset();
    send_range(0, 3);
    idle(18);
`ifdef LOADER_TIMEOUT_EN
    check_status("stall", 1'b0, 1'b1, 1'b1);
    check_writes("stall", 0);
`else
    check_status("stall", 1'b0, 1'b0, 1'b1);
    send_range(4, 10);
    idle(1);
    check_status("stall_done", 1'b1, 1'b0, 1'b0);
    check_writes("stall_done", 2);
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_junk_and_gaps();
    test_bad_count();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream boot stage for the single-cycle MIPS core.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes those words sequentially into the instruction ROM's write port.
- Holds the CPU in reset until a complete frame with a correct checksum has been loaded; a bad frame raises an error and the CPU stays in reset.

Parameters:
- N, 5, instruction memory word-address width; capacity 2^N words.
- SYNC, 8'hA5, frame start byte.
- TIMEOUT, 1024, inactivity limit in cycles (used only with LOADER_TIMEOUT_EN).

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one-cycle pulse.
- wr_addr  output  N  word address of the write.
- wr_data  output  32  word being written.
- cpu_reset  output  1  reset to the MIPS core; high until the load succeeds.
- done  output  1  load completed, checksum good.
- error  output  1  frame rejected.
- words_loaded  output  N+1  count of words written in the current frame.

Behaviour:
- Interface: Clk and Reset match the codebase's clock and reset names. Reset is synchronous and active-high; it is sampled only on the rising Clk edge.
- Byte transfer: a byte is accepted on a rising edge when in_valid and in_ready are both 1. in_ready is a combinational function of state: 1 in IDLE, COUNT, DATA, CHECK and ERROR; 0 in DONE.
- Reset values (registered outputs, effective after the edge with Reset=1):
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0; cpu_reset=1, done=0, error=0, words_loaded=0.
  - Internal byte index, word count and checksum are cleared.
  - Reset mid-frame abandons the frame; a pending wr_en is dropped.
- FSM:
  - IDLE: accepted byte == SYNC -> COUNT. Any other byte is discarded, state unchanged.
  - COUNT: accepted byte K.
    - K==0 or K>2^N -> ERROR.
    - Otherwise latch K, clear checksum and words_loaded -> DATA.
  - DATA: accept bytes b0..b3 per word; b0 is the MSB, so the word is {b0,b1,b2,b3}.
    - Checksum ^= each data byte.
    - On acceptance of b3: next cycle wr_en=1 for exactly one cycle, with wr_addr=word index and wr_data=assembled word. Word index starts at 0; words_loaded increments in the same cycle.
    - After the K-th word's b3 -> CHECK.
  - CHECK: accepted byte == checksum -> DONE; otherwise -> ERROR.
  - DONE: cpu_reset=0, done=1. Sticky until Reset; no bytes accepted.
  - ERROR: error=1, cpu_reset=1. Bytes are accepted and discarded. An accepted SYNC clears error and moves to COUNT (retry without Reset).
- Timing:
  - cpu_reset falls in the cycle after the checksum byte is accepted.
  - The last wr_en pulse always completes no later than the edge at which DONE is entered.
- Simultaneity: byte acceptance continues in the same cycle a wr_en pulse is issued; there are no stall cycles. The maximum rate is one byte per cycle.
- wr_addr and wr_data hold their last values when wr_en=0.
- A word index never exceeds K-1, so wr_addr cannot wrap.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: a counter clears on every accepted byte and on every state change. In COUNT, DATA or CHECK, reaching TIMEOUT cycles with no accepted byte -> ERROR. Any partially assembled word is not written.
- Undefined: no counter is instantiated; the loader waits indefinitely in any state.

Test Plan:
- Good frame, one byte per cycle: A5 02 20 08 00 05 8C 09 00 00 A8 -> writes 0x20080005 @0 and 0x8C090000 @1; words_loaded=2; done=1; cpu_reset falls the cycle after A8; error=0.
- Same frame with checksum 0xA9 -> both writes occur; error=1; cpu_reset stays 1; done=0. Then a full good frame -> done=1.
- Leading junk 00 FF 13 before A5, plus in_valid toggled every other cycle during DATA -> junk ignored, same writes and result as the first test.
- Count byte 0x00, and separately count 0x21 with N=5 -> ERROR immediately; no wr_en pulses.
- Reset asserted after 6 data bytes of a 2-word frame -> one write @0 only; all outputs at reset values; a new good frame then loads correctly from address 0.
- LOADER_TIMEOUT_EN, TIMEOUT=16: stall 16 cycles after 2 data bytes -> error=1, no write; without the macro the same stall leaves state in DATA and the frame completes when bytes resume.
